cb_read_sched: RTL and testbench

//  Command-driven sequencer for CB port-A reads and the CB_douta_map output stage.

---
 rtl/cb_read_sched_if.sv | 32 +++
 rtl/cb_read_sched.sv | 166 ++++++++++++++++
 tb/tb_cb_read_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cb_read_sched_if.sv
// Command/CB port-A bundle for cb_read_sched: command handshake in, read strobes and mapper controls out.
interface cb_read_sched_if #(
  parameter int CB_AW           = 10,
  parameter int SEQ_CNT_DW      = 10,
  parameter int CB_DOUTA_SEL_DW = 5
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [2:0]                 cmd_target;
  logic [1:0]                 cmd_dir;
  logic [CB_AW-1:0]           cmd_base;
  logic [SEQ_CNT_DW-1:0]      cmd_len;
  logic                       cmd_l_k_0;
  logic                       CB_ena;
  logic [CB_AW-1:0]           CB_addra;
  logic [SEQ_CNT_DW-1:0]      seq_cnt_out;
  logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel;
  logic                       l_k_0;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport slave (
    input  cmd_valid, cmd_target, cmd_dir, cmd_base, cmd_len, cmd_l_k_0,
    output cmd_ready, CB_ena, CB_addra, seq_cnt_out, CB_douta_sel, l_k_0, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_target, cmd_dir, cmd_base, cmd_len, cmd_l_k_0,
    input  cmd_ready, CB_ena, CB_addra, seq_cnt_out, CB_douta_sel, l_k_0, busy, done, err
  );
endinterface

// File: rtl/cb_read_sched.sv
// CB port-A read sequencer: issues len consecutive row reads from base, then waits RD_LAT
// cycles so the delayed mapper select covers the last returned row before signalling done.
module cb_read_sched #(
  parameter int L               = 4,
  parameter int CB_AW           = 10,
  parameter int SEQ_CNT_DW      = 10,
  parameter int CB_DOUTA_SEL_DW = 5,
  parameter int RD_LAT          = 2
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  cb_read_sched_if.slave  bus
);

  if (RD_LAT < 1 || RD_LAT > 7 || L < 1 || CB_DOUTA_SEL_DW != 5) begin : g_param_chk
    $error("cb_read_sched: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                tgt_q, tgt_d;
  logic [1:0]                dir_q, dir_d;
  logic [CB_AW-1:0]          base_q, base_d;
  logic [SEQ_CNT_DW-1:0]     len_q, len_d;
  logic [SEQ_CNT_DW-1:0]     seq_q, seq_d;
  logic [2:0]                drn_q, drn_d;
  logic                      ill_q, ill_d;

  logic                      ready_q, ready_d;
  logic                      ena_q, ena_d;
  logic [CB_AW-1:0]          addra_q, addra_d;
  logic [SEQ_CNT_DW-1:0]     seqo_q, seqo_d;
  logic                      lk_q, lk_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [RD_LAT-1:0]                       vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][CB_DOUTA_SEL_DW-1:0]  sel_pipe_q, sel_pipe_d;

  logic accept, illegal, tgt_ok;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    base_d  = base_q;
    len_d   = len_q;
    seq_d   = seq_q;
    drn_d   = drn_q;
    ill_d   = ill_q;
    ready_d = 1'b0;
    ena_d   = 1'b0;
    addra_d = '0;
    seqo_d  = '0;
    lk_d    = lk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    accept  = bus.cmd_valid && ready_q;
    tgt_ok  = bus.cmd_target inside {3'd1, 3'd2, 3'd3, 3'd4};
    // CBa_TBa only has a NEW mapping; every other target needs a nonzero direction
    illegal = !tgt_ok || (bus.cmd_dir == 2'b00) ||
              ((bus.cmd_target == 3'd4) && (bus.cmd_dir != 2'b11));

    unique case (state_q)
      S_IDLE: begin
        ready_d = !accept;
        if (accept) begin
          tgt_d   = bus.cmd_target;
          dir_d   = bus.cmd_dir;
          base_d  = bus.cmd_base;
          len_d   = bus.cmd_len;
          lk_d    = bus.cmd_l_k_0;
          seq_d   = '0;
          ill_d   = illegal;
          state_d = (illegal || bus.cmd_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        ena_d   = 1'b1;
        addra_d = base_q + CB_AW'(seq_q);
        seqo_d  = seq_q;
        seq_d   = seq_q + SEQ_CNT_DW'(1);
        if (seq_q == len_q - SEQ_CNT_DW'(1)) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end
      end
      S_DRAIN: begin
        if (drn_q == 3'(RD_LAT - 1)) state_d = S_DONE;
        else                         drn_d   = drn_q + 3'd1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        err_d   = ill_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_q != S_IDLE) || accept;

    // select follows each issued row by RD_LAT cycles, matching CB_douta arrival
    vld_pipe_d[0] = ena_q;
    sel_pipe_d[0] = {tgt_q, dir_q};
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      sel_pipe_d[i] = sel_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      dir_q      <= '0;
      base_q     <= '0;
      len_q      <= '0;
      seq_q      <= '0;
      drn_q      <= '0;
      ill_q      <= 1'b0;
      ready_q    <= 1'b0;
      ena_q      <= 1'b0;
      addra_q    <= '0;
      seqo_q     <= '0;
      lk_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
      sel_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      dir_q      <= dir_d;
      base_q     <= base_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      drn_q      <= drn_d;
      ill_q      <= ill_d;
      ready_q    <= ready_d;
      ena_q      <= ena_d;
      addra_q    <= addra_d;
      seqo_q     <= seqo_d;
      lk_q       <= lk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
      sel_pipe_q <= sel_pipe_d;
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.CB_ena       = ena_q;
  assign bus.CB_addra     = addra_q;
  assign bus.seq_cnt_out  = seqo_q;
  assign bus.CB_douta_sel = vld_pipe_q[RD_LAT-1] ? sel_pipe_q[RD_LAT-1] : '0;
  assign bus.l_k_0        = lk_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_cb_read_sched.sv
// Bench for cb_read_sched: timeline model of each accepted command, per-cycle compare, directed literals.
module tb_cb_read_sched;
  localparam int CB_AW = 10, SEQ_CNT_DW = 10, SEL_DW = 5, RD_LAT = 2;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  cb_read_sched_if #(.CB_AW(CB_AW), .SEQ_CNT_DW(SEQ_CNT_DW), .CB_DOUTA_SEL_DW(SEL_DW)) bus ();

  cb_read_sched #(.L(4), .CB_AW(CB_AW), .SEQ_CNT_DW(SEQ_CNT_DW),
                  .CB_DOUTA_SEL_DW(SEL_DW), .RD_LAT(RD_LAT))
    dut (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus.slave));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  bit started = 0;

  // model: one accepted command described by its accept edge and derived end edge
  int m_T, m_N, m_E, m_base, ready_from;
  bit m_act, m_legal, m_lk;
  logic [2:0] m_tgt;
  logic [1:0] m_dir;
  bit e_ready, e_ena, e_lk, e_busy, e_done, e_err;
  int e_seq, e_addra, e_sel;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endfunction

  function automatic bit legal_cmd(logic [2:0] t, logic [1:0] d);
    return (t >= 3'd1 && t <= 3'd4) && d != 2'b00 && !(t == 3'd4 && d != 2'b11);
  endfunction

  initial begin
    m_act = 0; m_lk = 0; ready_from = 1 << 30;
    m_T = 0; m_N = 0; m_E = -1; m_base = 0; m_legal = 0; m_tgt = 0; m_dir = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!sys_rst_n) begin
        m_act = 0; m_lk = 0; ready_from = cyc + 1;
      end else if (bus.cmd_valid && e_ready) begin
        m_act   = 1;
        m_T     = cyc;
        m_N     = int'(bus.cmd_len);
        m_base  = int'(bus.cmd_base);
        m_tgt   = bus.cmd_target;
        m_dir   = bus.cmd_dir;
        m_lk    = bus.cmd_l_k_0;
        m_legal = legal_cmd(bus.cmd_target, bus.cmd_dir);
        m_E     = (m_legal && m_N > 0) ? m_T + m_N + RD_LAT + 1 : m_T + 1;
        ready_from = m_E + 1;
      end
      e_ready = sys_rst_n && cyc >= ready_from;
      e_ena = 0; e_seq = 0; e_addra = 0; e_sel = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_lk = sys_rst_n ? m_lk : 0;
      if (sys_rst_n && m_act) begin
        if (m_legal && m_N > 0) begin
          e_ena = cyc >= m_T + 1 && cyc <= m_T + m_N;
          if (e_ena) begin
            e_seq   = cyc - m_T - 1;
            e_addra = (m_base + e_seq) % (1 << CB_AW);
          end
          if (cyc >= m_T + 1 + RD_LAT && cyc <= m_T + m_N + RD_LAT) e_sel = int'({m_tgt, m_dir});
        end
        e_busy = cyc >= m_T && cyc <= m_E;
        e_done = cyc == m_E;
        e_err  = e_done && !m_legal;
      end
      started = 1;
    end
  end

  // per-cycle compare, plus accept spacing observed on the DUT handshake
  int prev_acc = -1, prev_gap = 0;
  initial forever begin
    @(negedge clk);
    #1;
    if (started) begin
      chk("cmd_ready", int'(bus.cmd_ready), int'(e_ready));
      chk("CB_ena", int'(bus.CB_ena), int'(e_ena));
      if (e_ena) chk("CB_addra", int'(bus.CB_addra), e_addra);
      chk("seq_cnt_out", int'(bus.seq_cnt_out), e_seq);
      chk("CB_douta_sel", int'(bus.CB_douta_sel), e_sel);
      chk("l_k_0", int'(bus.l_k_0), int'(e_lk));
      chk("busy", int'(bus.busy), int'(e_busy));
      chk("done", int'(bus.done), int'(e_done));
      chk("err", int'(bus.err), int'(e_err));
      chk("ready_busy_excl", int'(bus.cmd_ready & bus.busy), 0);
      if (!sys_rst_n) prev_acc = -1;
      else if (bus.cmd_ready && bus.cmd_valid) begin
        if (prev_acc >= 0) chk("accept_gap_ok", int'((cyc + 1 - prev_acc) >= prev_gap), 1);
        if (legal_cmd(bus.cmd_target, bus.cmd_dir) && bus.cmd_len != 0) begin
          prev_acc = cyc + 1;
          prev_gap = int'(bus.cmd_len) + RD_LAT + 2;
        end else prev_acc = -1;
      end
    end
  end

  task automatic set_fields(input logic [2:0] t, input logic [1:0] d, input int base,
                            input int len, input bit lk);
    bus.cmd_target = t;
    bus.cmd_dir    = d;
    bus.cmd_base   = CB_AW'(base);
    bus.cmd_len    = SEQ_CNT_DW'(len);
    bus.cmd_l_k_0  = lk;
  endtask

  // returns with the accept edge just past (current sample is T)
  task automatic send(input logic [2:0] t, input logic [1:0] d, input int base,
                      input int len, input bit lk);
    int n = 0;
    while (!e_ready && n < 200) begin @(negedge clk); n++; end
    if (!e_ready) chk("wait_ready_timeout", 0, 1);
    set_fields(t, d, base, len, lk);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic rand_fields();
    set_fields(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 1023)), int'($urandom_range(0, 10)),
               1'($urandom_range(0, 1)));
  endtask

  int exp_addr[4];

  initial begin
    bus.cmd_valid = 1'b0;
    set_fields(3'd0, 2'd0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", int'(bus.cmd_ready), 0);
    chk("rst_ena", int'(bus.CB_ena), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sel", int'(bus.CB_douta_sel), 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // A/POS base 5 len 3
    send(3'd1, 2'b01, 5, 3, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      chk("lit_a_ena", int'(bus.CB_ena), int'(k <= 3));
      if (k <= 3) chk("lit_a_addra", int'(bus.CB_addra), 4 + k);
      chk("lit_a_sel", int'(bus.CB_douta_sel), (k >= 3 && k <= 5) ? 5 : 0);
      chk("lit_a_done", int'(bus.done), int'(k == 6));
    end

    // M/NEG with address wrap
    exp_addr = '{1022, 1023, 0, 1};
    send(3'd3, 2'b10, 1022, 4, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      if (k <= 4) begin
        chk("lit_m_addra", int'(bus.CB_addra), exp_addr[k-1]);
        chk("lit_m_seq", int'(bus.seq_cnt_out), k - 1);
      end
      chk("lit_m_sel", int'(bus.CB_douta_sel), (k >= 3 && k <= 6) ? 14 : 0);
      chk("lit_m_done", int'(bus.done), int'(k == 7));
    end

    // TBa/NEW, l_k_0 held past done
    send(3'd4, 2'b11, 100, 5, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (k <= 5) chk("lit_t_seq", int'(bus.seq_cnt_out), k - 1);
      chk("lit_t_sel", int'(bus.CB_douta_sel), (k >= 3 && k <= 7) ? 19 : 0);
      chk("lit_t_done", int'(bus.done), int'(k == 8));
    end
    chk("lit_t_lk_held", int'(bus.l_k_0), 1);

    // illegal commands and zero length
    send(3'd4, 2'b01, 0, 3, 1'b0);
    @(negedge clk); #1;
    chk("lit_ill1_done", int'(bus.done), 1);
    chk("lit_ill1_err", int'(bus.err), 1);
    chk("lit_ill1_ena", int'(bus.CB_ena), 0);
    send(3'd5, 2'b01, 0, 3, 1'b0);
    @(negedge clk); #1;
    chk("lit_ill2_done", int'(bus.done), 1);
    chk("lit_ill2_err", int'(bus.err), 1);
    send(3'd1, 2'b01, 0, 0, 1'b0);
    @(negedge clk); #1;
    chk("lit_len0_done", int'(bus.done), 1);
    chk("lit_len0_err", int'(bus.err), 0);
    chk("lit_len0_ena", int'(bus.CB_ena), 0);

    // reset two cycles into a len=8 read
    send(3'd2, 2'b01, 50, 8, 1'b1);
    @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk); #1;
    chk("lit_rst_ena", int'(bus.CB_ena), 0);
    chk("lit_rst_busy", int'(bus.busy), 0);
    chk("lit_rst_lk", int'(bus.l_k_0), 0);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      chk("lit_rst_no_done", int'(bus.done), 0);
    end
    send(3'd1, 2'b01, 7, 4, 1'b0);
    repeat (10) @(negedge clk);

    // cmd_valid held high with changing fields
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      set_fields(3'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
                 int'($urandom_range(0, 1023)), int'($urandom_range(1, 9)),
                 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;

    // fully random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      rand_fields();
      sys_rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    sys_rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
